clock_display_scan: RTL and testbench

// - Reader side of the SYSTEM_BUS time registers (HOUR/MINUTE/SECOND written by the time-of-day counter).
// - Takes a coherent snapshot of the time once per scan frame and converts each field to two BCD digits.
// - Drives a 6-digit multiplexed common-anode 7-segment display: HH MM SS.
// - Sits between the time counter and the board display pins.

---
 rtl/clock_display_scan.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_clock_display_scan.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// clock_display_scan
// Reads the HOUR/MINUTE/SECOND time registers, takes one coherent snapshot per
// scan frame, converts each field to two BCD digits and scans them onto a
// 6-digit common-anode 7-segment display (HH MM SS).
//
// Ports
//   CLK        in   1  system clock
//   rstn       in   1  asynchronous active-low reset
//   HOUR       in   5  binary hours, valid 0..23 (larger shows "--")
//   MINUTE     in   6  binary minutes, valid 0..59 (larger shows "--")
//   SECOND     in   6  binary seconds, valid 0..59 (larger shows "--")
//   SEG        out  7  segments {g,f,e,d,c,b,a}, active-low
//   DP         out  1  decimal point, active-low
//   DIGIT_SEL  out  6  digit enables, active-low one-hot; bit0 = hour tens
//   SNAP_MISS  out  1  sticky: a snapshot was force-committed after retries ran out
//
// Parameters
//   SCAN_DIV   clock cycles per digit slot (>= BLANK_CYC+2)
//   BLANK_CYC  dark cycles at the start of every slot (>= 1)
//   RETRY_MAX  snapshot compare retries before a forced commit (1..7)
//
// Optional feature macro: BLINK_COLON_EN
//   Defined   : DP lights on digits 1 and 3 while committed SECOND is even.
//   Undefined : DP is tied high.

module clock_display_scan #(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 2,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic       CLK,
    input  logic       rstn,
    input  logic [4:0] HOUR,
    input  logic [5:0] MINUTE,
    input  logic [5:0] SECOND,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [5:0] DIGIT_SEL,
    output logic       SNAP_MISS
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = $clog2(BLANK_CYC + 1);
    localparam int unsigned TW = 17;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC);
    localparam logic [2:0]    RETRY_LIM  = 3'(RETRY_MAX);
    localparam logic [3:0]    DASH       = 4'hA;
    localparam logic [6:0]    SEG_OFF    = 7'h7F;
    localparam logic [5:0]    SEL_OFF    = 6'h3F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAP_A,
        S_CAP_B,
        S_COMMIT
    } state_t;

    // Binary 0..59 to {tens, units} by successive compare/subtract.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        if (r >= 6'd50) begin
            t = 4'd5; r = r - 6'd50;
        end else if (r >= 6'd40) begin
            t = 4'd4; r = r - 6'd40;
        end else if (r >= 6'd30) begin
            t = 4'd3; r = r - 6'd30;
        end else if (r >= 6'd20) begin
            t = 4'd2; r = r - 6'd20;
        end else if (r >= 6'd10) begin
            t = 4'd1; r = r - 6'd10;
        end
        return {t, 4'(r)};
    endfunction

    // Active-low segment pattern; any non-decimal code renders as a dash.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [BW-1:0] r_blank;
    logic          r_armed;
    logic          r_boot;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_snap_a;
    logic [2:0]    r_retry;
    logic          r_snap_miss;
    logic [3:0]    r_bcd_h1, r_bcd_h0, r_bcd_m1, r_bcd_m0, r_bcd_s1, r_bcd_s0;
    logic [6:0]    r_seg;
    logic [5:0]    r_sel;

    logic          w_tick;
    logic          w_frame_start;
    logic [TW-1:0] w_live;
    logic          w_cap;
    logic          w_commit;
    logic          w_retry_inc;
    logic          w_miss_set;
    logic [7:0]    w_hour_bcd, w_min_bcd, w_sec_bcd;
    logic [3:0]    w_digit;
    logic          w_dark;

    assign w_tick        = (r_presc == PRESC_LAST);
    assign w_frame_start = w_tick && (r_idx == 3'd5);
    assign w_live        = {HOUR, MINUTE, SECOND};
    assign w_dark        = !r_armed || (r_blank != '0);

    // Slot timing: prescaler, digit index, per-slot blanking counter.
    // r_armed keeps the display dark from reset until the first slot boundary.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
            r_blank <= '0;
            r_armed <= 1'b0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
                r_blank <= BLANK_LOAD;
                r_armed <= 1'b1;
            end else begin
                r_presc <= r_presc + PW'(1);
                if (r_blank != '0) begin
                    r_blank <= r_blank - BW'(1);
                end
            end
        end
    end

    // Snapshot FSM state register.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_boot  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_boot  <= 1'b0;
        end
    end

    // Snapshot FSM next state; r_boot forces one capture right after reset.
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_commit    = 1'b0;
        w_retry_inc = 1'b0;
        w_miss_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_frame_start || r_boot) begin
                    w_state_nxt = S_CAP_A;
                end
            end
            S_CAP_A: begin
                w_cap       = 1'b1;
                w_state_nxt = S_CAP_B;
            end
            S_CAP_B: begin
                if (w_live == r_snap_a) begin
                    w_state_nxt = S_COMMIT;
                end else if (r_retry < RETRY_LIM) begin
                    w_retry_inc = 1'b1;
                    w_state_nxt = S_CAP_A;
                end else begin
                    w_miss_set  = 1'b1;
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Field conversion of the captured snapshot, with out-of-range dashes.
    always_comb begin
        w_hour_bcd = to_bcd({1'b0, r_snap_a[16:12]});
        w_min_bcd  = to_bcd(r_snap_a[11:6]);
        w_sec_bcd  = to_bcd(r_snap_a[5:0]);
        if (r_snap_a[16:12] > 5'd23) w_hour_bcd = {DASH, DASH};
        if (r_snap_a[11:6]  > 6'd59) w_min_bcd  = {DASH, DASH};
        if (r_snap_a[5:0]   > 6'd59) w_sec_bcd  = {DASH, DASH};
    end

    // Snapshot datapath: capture, retry count, sticky miss flag, BCD registers.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            r_snap_a    <= '0;
            r_retry     <= 3'd0;
            r_snap_miss <= 1'b0;
            r_bcd_h1    <= 4'd0;
            r_bcd_h0    <= 4'd0;
            r_bcd_m1    <= 4'd0;
            r_bcd_m0    <= 4'd0;
            r_bcd_s1    <= 4'd0;
            r_bcd_s0    <= 4'd0;
        end else begin
            if (w_cap)       r_snap_a    <= w_live;
            if (w_retry_inc) r_retry     <= r_retry + 3'd1;
            if (w_miss_set)  r_snap_miss <= 1'b1;
            if (w_commit) begin
                r_retry  <= 3'd0;
                r_bcd_h1 <= w_hour_bcd[7:4];
                r_bcd_h0 <= w_hour_bcd[3:0];
                r_bcd_m1 <= w_min_bcd[7:4];
                r_bcd_m0 <= w_min_bcd[3:0];
                r_bcd_s1 <= w_sec_bcd[7:4];
                r_bcd_s0 <= w_sec_bcd[3:0];
            end
        end
    end

    // Digit mux for the current slot.
    always_comb begin
        w_digit = DASH;
        case (r_idx)
            3'd0:    w_digit = r_bcd_h1;
            3'd1:    w_digit = r_bcd_h0;
            3'd2:    w_digit = r_bcd_m1;
            3'd3:    w_digit = r_bcd_m0;
            3'd4:    w_digit = r_bcd_s1;
            3'd5:    w_digit = r_bcd_s0;
            default: w_digit = DASH;
        endcase
    end

    // Registered segment and digit drive; both switch on the same edge.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            r_seg <= SEG_OFF;
            r_sel <= SEL_OFF;
        end else if (w_dark) begin
            r_seg <= SEG_OFF;
            r_sel <= SEL_OFF;
        end else begin
            r_seg <= seg_enc(w_digit);
            r_sel <= ~(6'b000001 << r_idx);
        end
    end

`ifdef BLINK_COLON_EN
    logic r_sec_lsb;
    logic r_dp;

    // Separator dots after HH and MM, lit on even committed seconds.
    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            r_sec_lsb <= 1'b0;
            r_dp      <= 1'b1;
        end else begin
            if (w_commit) r_sec_lsb <= r_snap_a[0];
            if (w_dark) begin
                r_dp <= 1'b1;
            end else begin
                r_dp <= !(((r_idx == 3'd1) || (r_idx == 3'd3)) && !r_sec_lsb);
            end
        end
    end

    assign DP = r_dp;
`else
    assign DP = 1'b1;
`endif

    assign SEG       = r_seg;
    assign DIGIT_SEL = r_sel;
    assign SNAP_MISS = r_snap_miss;

endmodule

// File: tb/tb_clock_display_scan.sv
// Testbench for clock_display_scan with SCAN_DIV=8, BLANK_CYC=2, RETRY_MAX=3.
// Expected digit slots are queued when the time inputs are set up and a
// negedge monitor pops them as each lit slot appears on the display.

module tb_clock_display_scan;

    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned RETRY_MAX = 3;
    localparam int unsigned ACTIVE    = SCAN_DIV - BLANK_CYC;

    logic       CLK = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] HOUR;
    logic [5:0] MINUTE;
    logic [5:0] SECOND;
    logic [6:0] SEG;
    logic       DP;
    logic [5:0] DIGIT_SEL;
    logic       SNAP_MISS;

    clock_display_scan #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC),
        .RETRY_MAX(RETRY_MAX)
    ) dut (
        .CLK      (CLK),
        .rstn     (rstn),
        .HOUR     (HOUR),
        .MINUTE   (MINUTE),
        .SECOND   (SECOND),
        .SEG      (SEG),
        .DP       (DP),
        .DIGIT_SEL(DIGIT_SEL),
        .SNAP_MISS(SNAP_MISS)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [5:0] sel;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic exp_dp(input int idx, input int s);
`ifdef BLINK_COLON_EN
        return !(((idx == 1) || (idx == 3)) && ((s % 2) == 0));
`else
        return 1'b1;
`endif
    endfunction

    // Queue the expected slots for digits first_idx..5 of time h:m:s (10 = dash).
    task automatic push_frame(input int h, input int m, input int s, input int first_idx);
        int         d[6];
        logic [5:0] one;
        exp_t       e;
        one  = 6'b000001;
        d[0] = (h > 23) ? 10 : h / 10;
        d[1] = (h > 23) ? 10 : h % 10;
        d[2] = (m > 59) ? 10 : m / 10;
        d[3] = (m > 59) ? 10 : m % 10;
        d[4] = (s > 59) ? 10 : s / 10;
        d[5] = (s > 59) ? 10 : s % 10;
        for (int i = first_idx; i < 6; i++) begin
            e.sel = ~(one << i);
            e.seg = exp_seg(d[i]);
            e.dp  = exp_dp(i, s);
            q.push_back(e);
        end
    endtask

    task automatic wait_on(input logic [5:0] sel);
        int n;
        n = 0;
        while (DIGIT_SEL !== sel && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("wait_on", 32'(DIGIT_SEL), 32'(sel));
    endtask

    task automatic wait_off(input logic [5:0] sel);
        int n;
        n = 0;
        while (DIGIT_SEL === sel && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("wait_off", (DIGIT_SEL === sel) ? 1 : 0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 150) begin
            @(negedge CLK);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    // Apply a time, let two frame boundaries pass, then check one whole frame.
    task automatic set_and_expect(input int h, input int m, input int s);
        HOUR   = 5'(h);
        MINUTE = 6'(m);
        SECOND = 6'(s);
        wait_on(6'h1F);
        wait_off(6'h1F);
        wait_on(6'h1F);
        wait_off(6'h1F);
        push_frame(h, m, s, 0);
        drain();
    endtask

    // Display monitor: slot start, slot length and blanking gap.
    bit   prev_lit = 1'b0;
    bit   lit;
    bit   cur_chk  = 1'b0;
    bit   prev_chk = 1'b0;
    int   lit_cnt  = 0;
    int   dark_cnt = 0;
    exp_t e_mon;

    always @(negedge CLK) begin
        if (!rstn) begin
            prev_lit = 1'b0;
            cur_chk  = 1'b0;
            prev_chk = 1'b0;
            lit_cnt  = 0;
            dark_cnt = 0;
        end else begin
            lit = (DIGIT_SEL !== 6'h3F);
            if (lit && !prev_lit) begin
                if (q.size() != 0) begin
                    if (prev_chk) check("blank_len", dark_cnt, BLANK_CYC);
                    e_mon = q.pop_front();
                    check("digit_sel", 32'(DIGIT_SEL), 32'(e_mon.sel));
                    check("seg", 32'(SEG), 32'(e_mon.seg));
                    check("dp", 32'(DP), 32'(e_mon.dp));
                    cur_chk = 1'b1;
                end else begin
                    cur_chk = 1'b0;
                end
                lit_cnt = 1;
            end else if (lit) begin
                lit_cnt++;
            end else if (prev_lit) begin
                if (cur_chk) begin
                    check("active_len", lit_cnt, ACTIVE);
                    check("blank_seg", 32'(SEG), 32'h7F);
                    check("blank_dp", 32'(DP), 1);
                end
                prev_chk = cur_chk;
                dark_cnt = 1;
            end else begin
                dark_cnt++;
            end
            prev_lit = lit;
        end
    end

    initial begin
        rstn   = 1'b0;
        HOUR   = 5'd12;
        MINUTE = 6'd10;
        SECOND = 6'd56;
        repeat (5) @(negedge CLK);
        check("rst_seg", 32'(SEG), 32'h7F);
        check("rst_sel", 32'(DIGIT_SEL), 32'h3F);
        check("rst_dp", 32'(DP), 1);
        check("rst_miss", 32'(SNAP_MISS), 0);

        // Torn boot snapshot: MINUTE moves every cycle; the 4th capture
        // (edge 8 after release) sees MINUTE=17 and is force-committed.
        push_frame(12, 17, 56, 1);
        rstn = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge CLK);
            if (n <= int'(BLANK_CYC)) check("post_rst_dark", 32'(DIGIT_SEL), 32'h3F);
            MINUTE = 6'(10 + n);
        end
        check("miss_set", 32'(SNAP_MISS), 1);
        drain();

        set_and_expect(12, 22, 56);
        check("miss_sticky", 32'(SNAP_MISS), 1);
        set_and_expect(12, 34, 56);
        set_and_expect(24, 5, 59);
        set_and_expect(23, 59, 0);
        set_and_expect(31, 60, 63);
        set_and_expect(0, 0, 10);
        set_and_expect(0, 0, 11);
        check("miss_sticky2", 32'(SNAP_MISS), 1);

        // Reset while the frame snapshot sits in CAP_B.
        wait_on(6'h1F);
        wait_off(6'h1F);
        rstn = 1'b0;
        #1;
        check("midrst_seg", 32'(SEG), 32'h7F);
        check("midrst_sel", 32'(DIGIT_SEL), 32'h3F);
        check("midrst_dp", 32'(DP), 1);
        check("midrst_miss", 32'(SNAP_MISS), 0);
        repeat (2) @(negedge CLK);
        rstn = 1'b1;
        for (int n = 1; n <= int'(BLANK_CYC); n++) begin
            @(negedge CLK);
            check("rerst_dark", 32'(DIGIT_SEL), 32'h3F);
        end
        set_and_expect(9, 8, 7);
        check("miss_clear", 32'(SNAP_MISS), 0);

        // Reset while a digit is lit darkens the display without a clock edge.
        wait_on(6'h3B);
        @(posedge CLK);
        #2;
        rstn = 1'b0;
        #1;
        check("litrst_sel", 32'(DIGIT_SEL), 32'h3F);
        check("litrst_seg", 32'(SEG), 32'h7F);
        check("litrst_dp", 32'(DP), 1);
        repeat (2) @(negedge CLK);
        rstn = 1'b1;
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
